// File: rtl/acs_pm_unit.sv
// Viterbi add-compare-select stage: path metric update, survivor decisions,
// best-state search and metric normalisation, one trellis step per cycle.
module acs_pm_unit #(
    parameter int NUM_STATES = 64,
    parameter int PM_W       = 8,
    parameter int SW         = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    frame_start,
    input  logic [4*NUM_STATES-1:0] bm_in,
    output logic                    dec_valid,
    output logic [NUM_STATES-1:0]   dec_out,
    output logic [SW-1:0]           best_state,
    output logic                    norm_evt,
    output logic [15:0]             step_cnt
);

    localparam int HALF = NUM_STATES / 2;
    localparam logic [PM_W-1:0] PM_INIT = {2'b01, {(PM_W-2){1'b0}}};

    logic [PM_W-1:0]       r_pm [NUM_STATES];
    logic                  r_dec_valid;
    logic [NUM_STATES-1:0] r_dec;
    logic [SW-1:0]         r_best;
    logic                  r_norm;
    logic [15:0]           r_step;

    logic [PM_W-1:0]       w_src [NUM_STATES];
    logic [PM_W-1:0]       w_sel [NUM_STATES];
    logic [PM_W-1:0]       w_new [NUM_STATES];
    logic [NUM_STATES-1:0] w_dec;
    logic [NUM_STATES-1:0] w_msb;
    logic                  w_norm;
    logic [SW-1:0]         w_best_idx;
    logic [PM_W-1:0]       w_best_val;

    // A frame start re-seeds from the init metrics instead of the registers.
    always_comb begin
        for (int s = 0; s < NUM_STATES; s++) begin
            if (frame_start)
                w_src[s] = (s == 0) ? '0 : PM_INIT;
            else
                w_src[s] = r_pm[s];
        end
    end

    for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
        localparam int P0 = s / 2;
        localparam int P1 = P0 + HALF;
        logic [PM_W:0] w_c0;
        logic [PM_W:0] w_c1;
        assign w_c0 = {1'b0, w_src[P0]}
                    + {{(PM_W-1){1'b0}}, bm_in[4*s +: 2]};
        assign w_c1 = {1'b0, w_src[P1]}
                    + {{(PM_W-1){1'b0}}, bm_in[4*s+2 +: 2]};
        assign w_dec[s] = (w_c1 < w_c0);
        assign w_sel[s] = w_dec[s] ? w_c1[PM_W-1:0] : w_c0[PM_W-1:0];
        assign w_msb[s] = w_sel[s][PM_W-1];
    end

    assign w_norm = &w_msb;

    always_comb begin
        for (int s = 0; s < NUM_STATES; s++) begin
            w_new[s] = w_sel[s];
            if (w_norm)
                w_new[s][PM_W-1] = 1'b0;
        end
    end

    // Strict less-than keeps the lowest index among equal minima.
    always_comb begin
        w_best_idx = '0;
        w_best_val = w_new[0];
        for (int s = 1; s < NUM_STATES; s++) begin
            if (w_new[s] < w_best_val) begin
                w_best_val = w_new[s];
                w_best_idx = SW'(s);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_STATES; s++)
                r_pm[s] <= (s == 0) ? '0 : PM_INIT;
            r_dec_valid <= 1'b0;
            r_dec       <= '0;
            r_best      <= '0;
            r_norm      <= 1'b0;
            r_step      <= '0;
        end else begin
            r_dec_valid <= in_valid;
            r_norm      <= in_valid & w_norm;
            if (in_valid) begin
                for (int s = 0; s < NUM_STATES; s++)
                    r_pm[s] <= w_new[s];
                r_dec  <= w_dec;
                r_best <= w_best_idx;
                if (frame_start)
                    r_step <= 16'd1;
                else if (r_step != 16'hFFFF)
                    r_step <= r_step + 16'd1;
            end
        end
    end

    assign dec_valid  = r_dec_valid;
    assign dec_out    = r_dec;
    assign best_state = r_best;
    assign norm_evt   = r_norm;
    assign step_cnt   = r_step;

endmodule
